var_delay_line: RTL and testbench
=================================

Name: var_delay_line

Overview:
- Runtime-programmable delay line for aligning pixel/coordinate streams in the video pipeline.
- Used where the compensation latency changes with mode, so a fixed shift-register delay does not fit.
- Stores samples in a circular buffer. A trailing read pointer, offset by the selected delay, produces the delayed stream.
- Tracks per-sample valid and suppresses output until the line has refilled after reset or a delay change.

Parameters:
- MAX_DELAY, 31, largest supported delay in enabled cycles; must be ≥1.
- LENGTH, 10, data width in bits.
- PW, 5, pointer/delay-select width; must satisfy 2^PW > MAX_DELAY.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; when low, all state holds.
- delay  input  PW  requested delay in enabled cycles.
- in  input  LENGTH  data in.
- in_valid  input  1  qualifies in.
- out  output  LENGTH  delayed data, registered.
- out_valid  output  1  delayed in_valid, gated by fill status, registered.
- delay_err  output  1  registered flag: requested delay was out of range this enabled cycle.

Behaviour:
- Reset (reset_n low, asynchronous assert; synchronous release on next clk edge):
  - out=0, out_valid=0, delay_err=0.
  - write pointer=0, fill counter=0, active delay=1.
  - All stored valid bits cleared. Data storage need not be cleared.
- Effective delay De:
  - delay=0 → De=1, delay_err=0.
  - 1..MAX_DELAY → De=delay, delay_err=0.
  - delay>MAX_DELAY → De=MAX_DELAY, delay_err=1.
  - delay_err updates only on enabled edges.
- Latency: with en high every cycle, (in, in_valid) sampled at edge k appears on (out, out_valid) after edge k+De. De=1 is equivalent to a single register. Latency counts enabled edges only; en low stretches it.
- en low: pointers, fill, out, out_valid and delay_err all hold; in is ignored.
- Each enabled edge:
  - Write (in, in_valid) at the write pointer.
  - Increment the pointer mod 2^PW.
  - Update out from the entry written De enabled edges earlier. For De=1, that is the value written on the previous enabled edge.
- Fill counter:
  - Increments on each enabled edge, saturating at MAX_DELAY.
  - out_valid = stored valid of the selected entry AND (fill ≥ De), evaluated before this edge's increment.
  - out is updated regardless of fill, but is meaningful only when out_valid=1.
- Delay change: on an enabled edge where De differs from the active delay:
  - Active delay takes De.
  - Fill counter resets to 1 (this edge's write counts).
  - out_valid=0 on that edge.
  - out_valid stays 0 for the next De−1 enabled edges, then follows delayed in_valid.
  - Buffer contents are not erased. Samples written before the change emerge with the new offset once fill ≥ De.
- Wrap-around: pointer arithmetic is modulo 2^PW. The read offset never exceeds MAX_DELAY < 2^PW, so a write never overwrites a sample still needed for output.
- Reset mid-stream: out_valid drops immediately (asynchronously). After release, the first valid output occurs De enabled edges after the first post-reset enabled edge with in_valid=1.
- Simultaneous delay change and in_valid: the sample is written and counts toward the refill.

Test Plan:
- Fixed delay: delay=4, en=1, in=ramp 1,2,3…, in_valid=1 from reset release → out_valid rises after edge 4; out=1 after edge 4, out=2 after edge 5; sequence matches in exactly 4 cycles later.
- Minimum/zero/out-of-range: delay=0 → single-cycle latency, delay_err=0. delay=40 with MAX_DELAY=31 → 31-cycle latency, delay_err=1 after the first enabled edge.
- Enable gating: delay=3, ramp input, en toggling 1,0,1,0… → out advances only on en=1 edges. Value written at enabled edge k appears 3 enabled edges later; out holds across en=0 cycles.
- Delay change mid-stream: run delay=8 steady, switch to delay=3 at edge 100 → out_valid=0 after edges 100–102, returns to 1 after edge 103. Output equals input from 3 enabled edges earlier.
- Wrap and valid gaps: delay=31, 200-cycle ramp, in_valid=0 on every 5th sample → out_valid low exactly 31 cycles after each gap. No data corruption across pointer wrap.
- Async reset mid-stream: assert reset_n=0 between edges during steady flow → out=0 and out_valid=0 immediately. After release, refill behaves as in the fixed-delay scenario.

Source files
------------

// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable delay line built on a circular buffer.
// A write pointer advances on every enabled edge. The read pointer trails it by
// the effective delay. A fill counter suppresses out_valid until the line has
// refilled after reset or after a change of delay.
//
// Ports:
//   clk       - system clock, all state on posedge
//   reset_n   - asynchronous active-low reset
//   en        - advance enable; when low, all state holds
//   delay     - requested delay in enabled cycles (0 -> 1, >MAX_DELAY -> clamp)
//   in        - data in
//   in_valid  - qualifies in
//   out       - delayed data (registered)
//   out_valid - delayed in_valid gated by fill status (registered)
//   delay_err - requested delay was out of range on the last enabled edge
module var_delay_line #(
    parameter int unsigned MAX_DELAY = 31,
    parameter int unsigned LENGTH    = 10,
    parameter int unsigned PW        = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PW-1:0]     delay,
    input  logic [LENGTH-1:0] in,
    input  logic              in_valid,
    output logic [LENGTH-1:0] out,
    output logic              out_valid,
    output logic              delay_err
);

    localparam int unsigned   DEPTH = 2 ** PW;
    localparam logic [PW-1:0] MAX_D = PW'(MAX_DELAY);
    localparam logic [PW-1:0] ONE   = PW'(1);

    logic [LENGTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_mem;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] active_delay;
    logic [PW-1:0] fill;

    logic [PW-1:0] eff_delay_c;
    logic [PW-1:0] rd_ptr_c;
    logic [PW-1:0] fill_next_c;
    logic          err_c;
    logic          change_c;
    logic          rd_valid_c;

    // Effective delay, range flag, read address and fill bookkeeping
    always_comb begin
        eff_delay_c = delay;
        err_c       = 1'b0;
        if (delay == '0) begin
            eff_delay_c = ONE;
        end else if (delay > MAX_D) begin
            eff_delay_c = MAX_D;
            err_c       = 1'b1;
        end

        change_c = (eff_delay_c != active_delay);
        rd_ptr_c = wr_ptr - eff_delay_c;

        // Fill is judged before this edge's increment; a delay change always
        // blanks the output on the edge it takes effect.
        rd_valid_c = valid_mem[rd_ptr_c] && (fill >= eff_delay_c) && !change_c;

        if (change_c) begin
            fill_next_c = ONE;
        end else if (fill >= MAX_D) begin
            fill_next_c = MAX_D;
        end else begin
            fill_next_c = fill + ONE;
        end
    end

    // Control state, valid bits and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            fill         <= '0;
            active_delay <= ONE;
            valid_mem    <= '0;
            out          <= '0;
            out_valid    <= 1'b0;
            delay_err    <= 1'b0;
        end else if (en) begin
            valid_mem[wr_ptr] <= in_valid;
            wr_ptr            <= wr_ptr + ONE;
            fill              <= fill_next_c;
            active_delay      <= eff_delay_c;
            out               <= data_mem[rd_ptr_c];
            out_valid         <= rd_valid_c;
            delay_err         <= err_c;
        end
    end

    // Data storage is not reset; stale entries are masked by the valid bits
    always_ff @(posedge clk) begin
        if (en) begin
            data_mem[wr_ptr] <= in;
        end
    end

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: scoreboard bench for var_delay_line (MAX_DELAY=31, PW=6).
// Every driven cycle computes the expected output from a sample-history model
// and pushes it to a queue; the expectation is popped and compared after the edge.
module tb_var_delay_line;

    localparam int unsigned MAXD = 31;
    localparam int unsigned LEN  = 10;
    localparam int unsigned PWB  = 6;

    typedef struct packed {
        logic           v;
        logic [LEN-1:0] d;
    } smp_t;

    typedef struct packed {
        logic           v;
        logic           err;
        logic [LEN-1:0] d;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic            en;
    logic [PWB-1:0]  delay;
    logic [LEN-1:0]  in;
    logic            in_valid;
    logic [LEN-1:0]  out;
    logic            out_valid;
    logic            delay_err;

    int checks;
    int errors;

    smp_t hist[$];
    exp_t sb[$];
    int   m_fill;
    int   m_active;
    exp_t m_cur;

    var_delay_line #(.MAX_DELAY(MAXD), .LENGTH(LEN), .PW(PWB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .delay     (delay),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .delay_err (delay_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        hist.delete();
        sb.delete();
        m_fill   = 0;
        m_active = 1;
        m_cur    = '0;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        en       = 1'b0;
        delay    = '0;
        in       = '0;
        in_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Drive one cycle, push the expected post-edge outputs, advance past the edge
    task automatic drive(input logic e, input int dly, input int din, input logic vin);
        int   de;
        logic err;
        logic chg;
        smp_t s;
        en       = e;
        delay    = PWB'(dly);
        in       = LEN'(din);
        in_valid = vin;
        if (e) begin
            de  = (dly == 0) ? 1 : ((dly > int'(MAXD)) ? int'(MAXD) : dly);
            err = (dly > int'(MAXD));
            chg = (de != m_active);
            if (hist.size() >= de) s = hist[hist.size() - de];
            else                   s = '0;
            m_cur.v   = s.v && (m_fill >= de) && !chg;
            m_cur.d   = s.d;
            m_cur.err = err;
            m_fill    = chg ? 1 : ((m_fill + 1 > int'(MAXD)) ? int'(MAXD) : m_fill + 1);
            m_active  = de;
            hist.push_back('{v: vin, d: LEN'(din)});
            if (hist.size() > 64) void'(hist.pop_front());
        end
        sb.push_back(m_cur);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || delay_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%0d out_valid=%b delay_err=%b, expected 0/0/0",
                     out, out_valid, delay_err);
        end
    endtask

    task automatic test_fixed_delay();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 4, i + 1, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL fixed[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
            if (i == 3) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fixed_edge3: out_valid=%b, expected 0", out_valid);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out !== LEN'(i - 3)) begin
                    errors++;
                    $display("FAIL fixed_edge%0d: out=%0d v=%b, expected out=%0d v=1",
                             i, out, out_valid, i - 3);
                end
            end
        end
    endtask

    task automatic test_min_and_range();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 0, 100 + i, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL zero_delay[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
        end
        for (int i = 0; i < 45; i++) begin
            drive(1'b1, 40, 200 + i, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL over_range[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
            if (i == 0) begin
                checks++;
                if (delay_err !== 1'b1) begin
                    errors++;
                    $display("FAIL over_range_err: delay_err=%b, expected 1", delay_err);
                end
            end
            if (i == 31) begin
                checks++;
                if (out_valid !== 1'b1 || out !== LEN'(200)) begin
                    errors++;
                    $display("FAIL over_range_latency: out=%0d v=%b, expected out=200 v=1",
                             out, out_valid);
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            drive(((i % 2) == 0), 3, i + 1, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL enable[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
        end
    endtask

    task automatic test_delay_change();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            drive(1'b1, (i < 100) ? 8 : 3, i + 1, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL change[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
            if (i >= 100 && i <= 102) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL change_blank[%0d]: out_valid=%b, expected 0", i, out_valid);
                end
            end
            if (i == 103) begin
                checks++;
                if (out_valid !== 1'b1 || out !== LEN'(101)) begin
                    errors++;
                    $display("FAIL change_resume: out=%0d v=%b, expected out=101 v=1",
                             out, out_valid);
                end
            end
        end
    endtask

    task automatic test_wrap_gaps();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 31, i + 1, ((i % 5) != 4));
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL wrap[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4, 500 + i, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL pre_reset[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || delay_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%0d out_valid=%b delay_err=%b, expected 0/0/0",
                     out, out_valid, delay_err);
        end
        model_clear();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 4, 700 + i, 1'b1);
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || delay_err !== e.err || (e.v && out !== e.d)) begin
                errors++;
                $display("FAIL post_reset[%0d]: out=%0d v=%b err=%b, expected out=%0d v=%b err=%b",
                         i, out, out_valid, delay_err, e.d, e.v, e.err);
            end
            if (i == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out !== LEN'(700)) begin
                    errors++;
                    $display("FAIL post_reset_first: out=%0d v=%b, expected out=700 v=1",
                             out, out_valid);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed_delay();
        test_min_and_range();
        test_enable_gating();
        test_delay_change();
        test_wrap_gaps();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
